// File: rtl/data_memory_bank.sv
// +--------------------------------------------------------------------------+
// | Module   : data_memory_bank                                              |
// | Purpose  : Word-organised data memory with byte/half/word access, sign/  |
// |            zero extension, alignment and range checking, a registered    |
// |            read and valid/ready request/response handshakes.             |
// | Ports    : clk, reset (async, active-low)                                |
// |            req_valid/req_ready/req_write/req_size/req_unsigned/          |
// |            req_addr/req_wdata : request channel                          |
// |            rsp_valid/rsp_ready/rsp_rdata/rsp_error : response channel    |
// | Options  : DMEM_CLEAR_EN - zero every word after reset (one word per     |
// |            cycle) before the first request is accepted.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_memory_bank #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

`ifdef DMEM_CLEAR_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  // Address decode. BASE_ADDR is word aligned, so the low two offset bits
  // equal the low two address bits and give the byte lane directly.
  logic [ADDR_WIDTH-1:0] offset;
  logic [1:0]            lane;
  logic [IDX_W-1:0]      mem_idx;
  logic                  range_err, align_err, size_err, req_err;
  logic                  accept;

  assign offset    = req_addr - BASE_ADDR;
  assign lane      = offset[1:0];
  assign mem_idx   = offset[IDX_W+1:2];
  assign range_err = (req_addr < BASE_ADDR) ||
                     (offset[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH));
  assign size_err  = (req_size == 2'b11);
  assign align_err = ((req_size == 2'b01) && lane[0]) ||
                     ((req_size == 2'b10) && (lane != 2'b00));
  assign req_err   = range_err || size_err || align_err;
  assign accept    = req_valid && req_ready;

  // FSM: state register and next-state / ready logic.
`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0] clear_idx_q, clear_idx_d;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
`ifdef DMEM_CLEAR_EN
    clear_idx_d = clear_idx_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef DMEM_CLEAR_EN
        clear_idx_d = clear_idx_q + 1'b1;
        if (clear_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
`endif
      end
      ST_RUN: begin
        req_ready = !rsp_valid_q || rsp_ready;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
`ifdef DMEM_CLEAR_EN
      clear_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DMEM_CLEAR_EN
      clear_idx_q <= clear_idx_d;
`endif
    end
  end

  // Write port: the clear sweep owns the array while in INIT; afterwards only
  // accepted, error-free stores write, and only their enabled byte lanes.
  logic             wr_en;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic [IDX_W-1:0] wr_idx;

  always_comb begin
    wr_en   = 1'b0;
    wr_be   = 4'h0;
    wr_data = 32'h0;
    wr_idx  = mem_idx;
`ifdef DMEM_CLEAR_EN
    if (state_q == ST_INIT) begin
      wr_en  = 1'b1;
      wr_be  = 4'hF;
      wr_idx = clear_idx_q;
    end else
`endif
    if (accept && req_write && !req_err) begin
      wr_en = 1'b1;
      case (req_size)
        2'b00: begin
          wr_be   = 4'b0001 << lane;
          wr_data = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wr_be   = lane[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{req_wdata[15:0]}};
        end
        default: begin
          wr_be   = 4'hF;
          wr_data = req_wdata;
        end
      endcase
    end
  end

  // The array itself carries no reset; clearing is the sweep's job.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Load path: the word is sampled at the accept edge. A store on the
  // previous edge has already updated the array, so no forwarding is needed.
  logic [31:0] rd_word, rd_shift, load_data;

  assign rd_word  = mem[mem_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (req_size)
      2'b00: load_data = req_unsigned ? {24'h0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01: load_data = req_unsigned ? {16'h0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
      2'b10: load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  // Response register: loads on accept, otherwise holds until consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (req_write || req_err) ? 32'h0 : load_data;
      rsp_error_d = req_err;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_bank.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_data_memory_bank                                           |
// | Purpose  : Self-checking bench for data_memory_bank. Requests are driven |
// |            through a handshake task that pushes the expected response    |
// |            into a scoreboard queue; a monitor pops and compares each     |
// |            response as it is consumed.                                   |
// | Options  : DMEM_CLEAR_EN - also checks the clear sweep timing/contents.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_data_memory_bank;

  localparam int unsigned DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  data_memory_bank #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(32),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: sampled on the falling edge, so a response seen here
  // with rsp_ready high is consumed on the following rising edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        check_val({e.tag, "_err"}, {31'd0, rsp_error}, {31'd0, e.err});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Drives one request, holding it until accepted; leaves req_valid high so
  // consecutive calls issue back-to-back. Entered and left at posedge+1.
  task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    exp_t e;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check_val({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) return;
      @(posedge clk);
      #1;
    end
    check_val({tag, "_drain_timeout"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  // Counts falling edges with req_ready low until it rises.
  task automatic count_ready_low(output int n);
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        @(posedge clk);
        #1;
        return;
      end
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  int n_low;

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    reset = 1'b1;

`ifdef DMEM_CLEAR_EN
    count_ready_low(n_low);
    check_val("sweep_ready_low_cycles", n_low, DEPTH);
    send(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 32'h0, 1'b0, "lw_1fc_cleared");
    idle();
`else
    @(negedge clk);
    check_val("ready_after_release", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
`endif

    // Store then loads of every width/extension, back-to-back.
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 32'h0, 1'b0, "sw_10");
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, "lw_10");
    send(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, "lb_13");
    send(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000088, 1'b0, "lbu_13");
    send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, "lh_12");
    send(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AABB, 1'b0, "lhu_10");
    send(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456CC, 32'h0, 1'b0, "sb_11");
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899CCBB, 1'b0, "lw_after_sb");
    send(1'b1, 2'b01, 1'b0, 32'h12, 32'h00007777, 32'h0, 1'b0, "sh_12");
    send(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h7777CCBB, 1'b0, "lw_after_sh");

    // Error cases and range boundary.
    send(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, "sw_0");
    send(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, "lw_misaligned");
    send(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1, "lh_misaligned");
    send(1'b1, 2'b10, 1'b0, 32'h800, 32'hDEADBEEF, 32'h0, 1'b1, "sw_out_of_range");
    send(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "lw_0_unchanged");
    send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "size_reserved");
    send(1'b1, 2'b10, 1'b0, 32'h7FC, 32'h13579BDF, 32'h0, 1'b0, "sw_last_word");
    send(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 32'h13579BDF, 1'b0, "lw_last_word");
    send(1'b0, 2'b00, 1'b0, 32'h801, 32'h0, 32'h0, 1'b1, "lb_past_end");
    idle();
    wait_drain("basic");

    // Backpressure: one held response, then a burst of four loads.
    rsp_ready = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h7777CCBB, 1'b0, "bp_held");
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("bp_rsp_rdata", rsp_rdata, 32'h7777CCBB);
      check_val("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    pop_cyc.delete();
    rsp_ready = 1'b1;
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h7777CCBB, 1'b0, "burst0");
    send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, "burst1");
    send(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00007777, 1'b0, "burst2");
    send(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "burst3");
    idle();
    wait_drain("burst");
    @(posedge clk);
    #1;
    check_val("burst_rsp_count", pop_cyc.size(), 32'd5);
    if (pop_cyc.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        check_val("burst_consecutive", pop_cyc[i+1] - pop_cyc[i], 32'd1);
      end
    end

    // Asynchronous reset drops an in-flight response without a clock edge.
    rsp_ready = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h7777CCBB, 1'b0, "rst_inflight");
    idle();
    check_val("inflight_valid_before", {31'd0, rsp_valid}, 32'd1);
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    check_val("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("async_rst_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    rsp_ready = 1'b1;

`ifdef DMEM_CLEAR_EN
    count_ready_low(n_low);
    check_val("sweep_after_async_rst", n_low, DEPTH);
    // Reset in the middle of a sweep restarts it from word 0.
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    count_ready_low(n_low);
    check_val("sweep_restart_cycles", n_low, DEPTH);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "lw_10_recleared");
    idle();
    wait_drain("sweep");
`else
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h7777CCBB, 1'b0, "lw_after_rst");
    idle();
    wait_drain("post_rst");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
